// File: rtl/pipe_ctrl_unit.sv
// Control unit for the 5-stage MIPS pipeline: decodes in ID, resolves branches and
// jumps in ID, raises hazard stalls and carries control through ID/EX, EX/MEM, MEM/WB.
module pipe_ctrl_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 3,
  parameter int LINK_REG    = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opCode,
  input  logic [5:0]            func,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  zero,
  output logic [1:0]            pcSrc,
  output logic                  flush,
  output logic                  stall,
  output logic [1:0]            ex_ALUOp,
  output logic                  ex_ALUSrc,
  output logic [1:0]            ex_regDst,
  output logic                  mem_memRead,
  output logic                  mem_memWrite,
  output logic                  wb_regWrite,
  output logic [1:0]            wb_regSrc,
  output logic [REG_ADDR_W-1:0] wb_dst
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_SLT  = 2'd2;
  localparam logic [1:0] ALU_MUL  = 2'd3;

  localparam logic [1:0] DST_RT   = 2'd0;
  localparam logic [1:0] DST_RD   = 2'd1;
  localparam logic [1:0] DST_LINK = 2'd2;

  localparam logic [1:0] SRC_LINK = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_ALU  = 2'd2;

  localparam logic [1:0] PC_SEQ   = 2'd0;
  localparam logic [1:0] PC_JUMP  = 2'd2;
  localparam logic [1:0] PC_REG   = 2'd3;

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REG_ADDR_W-1:0] REG_ZERO  = {REG_ADDR_W{1'b0}};
  localparam logic [REG_ADDR_W-1:0] LINK_ADDR = REG_ADDR_W'(LINK_REG);

  // Register $0 is hard-wired, so it never creates a dependency.
  function automatic logic src_match(input logic [REG_ADDR_W-1:0] dst,
                                     input logic [REG_ADDR_W-1:0] src_a,
                                     input logic [REG_ADDR_W-1:0] src_b,
                                     input logic use_a,
                                     input logic use_b);
    return (dst != REG_ZERO) && ((use_a && (dst == src_a)) || (use_b && (dst == src_b)));
  endfunction

  logic [1:0]            id_alu_op_s;
  logic                  id_alu_src_s;
  logic [1:0]            id_reg_dst_s;
  logic                  id_mem_read_s;
  logic                  id_mem_write_s;
  logic                  id_reg_write_s;
  logic [1:0]            id_reg_src_s;
  logic                  id_is_mult_s;
  logic                  id_is_jr_s;
  logic                  id_use_rs_s;
  logic                  id_use_rt_s;
  logic [REG_ADDR_W-1:0] id_dst_s;
  logic                  id_is_branch_s;

  logic                  mul_busy_s;
  logic                  load_use_s;
  logic                  br_hazard_s;
  logic                  stall_s;

  logic [1:0]            ex_alu_op_q,    ex_alu_op_d;
  logic                  ex_alu_src_q,   ex_alu_src_d;
  logic [1:0]            ex_reg_dst_q,   ex_reg_dst_d;
  logic                  ex_mem_read_q,  ex_mem_read_d;
  logic                  ex_mem_write_q, ex_mem_write_d;
  logic                  ex_reg_write_q, ex_reg_write_d;
  logic [1:0]            ex_reg_src_q,   ex_reg_src_d;
  logic [REG_ADDR_W-1:0] ex_dst_q,       ex_dst_d;
  logic                  mem_mem_read_q,  mem_mem_read_d;
  logic                  mem_mem_write_q, mem_mem_write_d;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic [1:0]            mem_reg_src_q,   mem_reg_src_d;
  logic [REG_ADDR_W-1:0] mem_dst_q,       mem_dst_d;
  logic                  wb_reg_write_q,  wb_reg_write_d;
  logic [1:0]            wb_reg_src_q,    wb_reg_src_d;
  logic [REG_ADDR_W-1:0] wb_dst_q,        wb_dst_d;
  logic [CNT_W-1:0]      mul_cnt_q,       mul_cnt_d;

  // ID-stage decode of opcode/func into control bits and source usage.
  always_comb begin
    id_alu_op_s    = ALU_ADD;
    id_alu_src_s   = 1'b0;
    id_reg_dst_s   = DST_RT;
    id_mem_read_s  = 1'b0;
    id_mem_write_s = 1'b0;
    id_reg_write_s = 1'b0;
    id_reg_src_s   = SRC_LINK;
    id_is_mult_s   = 1'b0;
    id_is_jr_s     = 1'b0;
    id_use_rs_s    = 1'b1;
    id_use_rt_s    = 1'b0;
    case (opCode)
      OP_RTYPE: begin
        id_use_rt_s = 1'b1;
        case (func)
          FN_ADD: begin
            id_reg_dst_s = DST_RD; id_reg_write_s = 1'b1; id_reg_src_s = SRC_ALU;
          end
          FN_SUB: begin
            id_alu_op_s = ALU_SUB;
            id_reg_dst_s = DST_RD; id_reg_write_s = 1'b1; id_reg_src_s = SRC_ALU;
          end
          FN_SLT: begin
            id_alu_op_s = ALU_SLT;
            id_reg_dst_s = DST_RD; id_reg_write_s = 1'b1; id_reg_src_s = SRC_ALU;
          end
          FN_MULT: begin
            id_alu_op_s = ALU_MUL; id_is_mult_s = 1'b1;
            id_reg_dst_s = DST_RD; id_reg_write_s = 1'b1; id_reg_src_s = SRC_ALU;
          end
          FN_JR:   id_is_jr_s = 1'b1;
          default: id_is_jr_s = 1'b0;
        endcase
      end
      OP_ADDI: begin
        id_alu_src_s = 1'b1; id_reg_write_s = 1'b1; id_reg_src_s = SRC_ALU;
      end
      OP_SLTI: begin
        id_alu_op_s = ALU_SLT; id_alu_src_s = 1'b1;
        id_reg_write_s = 1'b1; id_reg_src_s = SRC_ALU;
      end
      OP_LW: begin
        id_alu_src_s = 1'b1; id_mem_read_s = 1'b1;
        id_reg_write_s = 1'b1; id_reg_src_s = SRC_MEM;
      end
      OP_SW: begin
        id_alu_src_s = 1'b1; id_mem_write_s = 1'b1; id_use_rt_s = 1'b1;
      end
      OP_J:    id_use_rs_s = 1'b0;
      OP_JAL: begin
        id_use_rs_s = 1'b0; id_reg_dst_s = DST_LINK;
        id_reg_write_s = 1'b1; id_reg_src_s = SRC_LINK;
      end
      OP_BEQ, OP_BNE: begin
        id_alu_op_s = ALU_SUB; id_use_rt_s = 1'b1;
      end
      default: id_use_rs_s = 1'b1;
    endcase
  end

  // Destination resolved in ID; non-writing instructions carry register 0.
  always_comb begin
    id_dst_s = REG_ZERO;
    if (id_reg_write_s) begin
      case (id_reg_dst_s)
        DST_RT:   id_dst_s = rt;
        DST_RD:   id_dst_s = rd;
        DST_LINK: id_dst_s = LINK_ADDR;
        default:  id_dst_s = REG_ZERO;
      endcase
    end else begin
      id_dst_s = REG_ZERO;
    end
  end

  assign id_is_branch_s = (opCode == OP_BEQ) || (opCode == OP_BNE) || id_is_jr_s;
  assign mul_busy_s     = (mul_cnt_q != CNT_ZERO);
  assign load_use_s     = ex_mem_read_q &&
                          src_match(ex_dst_q, rs, rt, id_use_rs_s, id_use_rt_s);
  assign br_hazard_s    = id_is_branch_s &&
                          ((ex_reg_write_q && src_match(ex_dst_q, rs, rt, id_use_rs_s, id_use_rt_s)) ||
                           (mem_mem_read_q && src_match(mem_dst_q, rs, rt, id_use_rs_s, id_use_rt_s)));
  assign stall_s        = mul_busy_s || load_use_s || br_hazard_s;

  // PC select, IF/ID flush and stall; reset and any stall suppress redirects.
  always_comb begin
    pcSrc = PC_SEQ;
    flush = 1'b0;
    stall = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (stall_s) begin
      stall = 1'b1;
    end else begin
      case (opCode)
        OP_BEQ:        begin pcSrc = {1'b0, zero};  flush = zero;  end
        OP_BNE:        begin pcSrc = {1'b0, ~zero}; flush = ~zero; end
        OP_J, OP_JAL:  begin pcSrc = PC_JUMP;       flush = 1'b1;  end
        OP_RTYPE: begin
          if (id_is_jr_s) begin
            pcSrc = PC_REG; flush = 1'b1;
          end else begin
            pcSrc = PC_SEQ; flush = 1'b0;
          end
        end
        default:       begin pcSrc = PC_SEQ;        flush = 1'b0;  end
      endcase
    end
  end

  // Stage-register next state: multiply holds ID/EX, other stalls inject a bubble.
  always_comb begin
    ex_alu_op_d     = ex_alu_op_q;
    ex_alu_src_d    = ex_alu_src_q;
    ex_reg_dst_d    = ex_reg_dst_q;
    ex_mem_read_d   = ex_mem_read_q;
    ex_mem_write_d  = ex_mem_write_q;
    ex_reg_write_d  = ex_reg_write_q;
    ex_reg_src_d    = ex_reg_src_q;
    ex_dst_d        = ex_dst_q;
    mem_mem_read_d  = ex_mem_read_q;
    mem_mem_write_d = ex_mem_write_q;
    mem_reg_write_d = ex_reg_write_q;
    mem_reg_src_d   = ex_reg_src_q;
    mem_dst_d       = ex_dst_q;
    wb_reg_write_d  = mem_reg_write_q;
    wb_reg_src_d    = mem_reg_src_q;
    wb_dst_d        = mem_dst_q;
    mul_cnt_d       = CNT_ZERO;
    if (mul_busy_s) begin
      mem_mem_read_d  = 1'b0;
      mem_mem_write_d = 1'b0;
      mem_reg_write_d = 1'b0;
      mem_reg_src_d   = SRC_LINK;
      mem_dst_d       = REG_ZERO;
      mul_cnt_d       = mul_cnt_q - CNT_ONE;
    end else if (stall_s) begin
      ex_alu_op_d    = ALU_ADD;
      ex_alu_src_d   = 1'b0;
      ex_reg_dst_d   = DST_RT;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      ex_reg_write_d = 1'b0;
      ex_reg_src_d   = SRC_LINK;
      ex_dst_d       = REG_ZERO;
    end else begin
      ex_alu_op_d    = id_alu_op_s;
      ex_alu_src_d   = id_alu_src_s;
      ex_reg_dst_d   = id_reg_dst_s;
      ex_mem_read_d  = id_mem_read_s;
      ex_mem_write_d = id_mem_write_s;
      ex_reg_write_d = id_reg_write_s;
      ex_reg_src_d   = id_reg_src_s;
      ex_dst_d       = id_dst_s;
      mul_cnt_d      = id_is_mult_s ? MUL_LOAD : CNT_ZERO;
    end
  end

  // Stage registers and multiply counter with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_alu_op_q     <= ALU_ADD;
      ex_alu_src_q    <= 1'b0;
      ex_reg_dst_q    <= DST_RT;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_reg_write_q  <= 1'b0;
      ex_reg_src_q    <= SRC_LINK;
      ex_dst_q        <= REG_ZERO;
      mem_mem_read_q  <= 1'b0;
      mem_mem_write_q <= 1'b0;
      mem_reg_write_q <= 1'b0;
      mem_reg_src_q   <= SRC_LINK;
      mem_dst_q       <= REG_ZERO;
      wb_reg_write_q  <= 1'b0;
      wb_reg_src_q    <= SRC_LINK;
      wb_dst_q        <= REG_ZERO;
      mul_cnt_q       <= CNT_ZERO;
    end else begin
      ex_alu_op_q     <= ex_alu_op_d;
      ex_alu_src_q    <= ex_alu_src_d;
      ex_reg_dst_q    <= ex_reg_dst_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_reg_src_q    <= ex_reg_src_d;
      ex_dst_q        <= ex_dst_d;
      mem_mem_read_q  <= mem_mem_read_d;
      mem_mem_write_q <= mem_mem_write_d;
      mem_reg_write_q <= mem_reg_write_d;
      mem_reg_src_q   <= mem_reg_src_d;
      mem_dst_q       <= mem_dst_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_reg_src_q    <= wb_reg_src_d;
      wb_dst_q        <= wb_dst_d;
      mul_cnt_q       <= mul_cnt_d;
    end
  end

  assign ex_ALUOp     = ex_alu_op_q;
  assign ex_ALUSrc    = ex_alu_src_q;
  assign ex_regDst    = ex_reg_dst_q;
  assign mem_memRead  = mem_mem_read_q;
  assign mem_memWrite = mem_mem_write_q;
  assign wb_regWrite  = wb_reg_write_q;
  assign wb_regSrc    = wb_reg_src_q;
  assign wb_dst       = wb_dst_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: a cycle-by-cycle vector table plus hand
// sequences for multiply, reset and reset-during-multiply.
module tb_pipe_ctrl_unit;

  localparam int R = 0, J = 2, JAL = 3, BEQ = 4, BNE = 5, ADDI = 8, SLTI = 10;
  localparam int LW = 35, SW = 43, NOP = 63;
  localparam int F_JR = 8, F_MULT = 24, F_ADD = 32, F_SUB = 34, F_SLT = 42;

  typedef struct {
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       z;
    logic [1:0] pc;
    logic       fl, st;
    logic [1:0] aop;
    logic       asrc;
    logic [1:0] rdst;
    logic       mr, mw, wr;
    logic [1:0] wsrc;
    logic [4:0] wdst;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opCode, func;
  logic [4:0] rs, rt, rd;
  logic zero;

  logic [1:0] pcSrc, ex_ALUOp, ex_regDst, wb_regSrc;
  logic flush, stall, ex_ALUSrc, mem_memRead, mem_memWrite, wb_regWrite;
  logic [4:0] wb_dst;
  logic [1:0] s_pcSrc, s_ex_ALUOp, s_ex_regDst, s_wb_regSrc;
  logic s_flush, s_stall, s_ex_ALUSrc, s_mem_memRead, s_mem_memWrite, s_wb_regWrite;
  logic [4:0] s_wb_dst;

  int errors = 0;
  int checks = 0;
  vec_t tbl [29];

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.REG_ADDR_W(5), .MUL_LATENCY(4), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .zero(zero), .pcSrc(pcSrc), .flush(flush), .stall(stall), .ex_ALUOp(ex_ALUOp),
    .ex_ALUSrc(ex_ALUSrc), .ex_regDst(ex_regDst), .mem_memRead(mem_memRead),
    .mem_memWrite(mem_memWrite), .wb_regWrite(wb_regWrite), .wb_regSrc(wb_regSrc),
    .wb_dst(wb_dst));

  pipe_ctrl_unit #(.REG_ADDR_W(5), .MUL_LATENCY(1), .LINK_REG(31)) dut1 (
    .clk(clk), .rst(rst), .opCode(opCode), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .zero(zero), .pcSrc(s_pcSrc), .flush(s_flush), .stall(s_stall), .ex_ALUOp(s_ex_ALUOp),
    .ex_ALUSrc(s_ex_ALUSrc), .ex_regDst(s_ex_regDst), .mem_memRead(s_mem_memRead),
    .mem_memWrite(s_mem_memWrite), .wb_regWrite(s_wb_regWrite), .wb_regSrc(s_wb_regSrc),
    .wb_dst(s_wb_dst));

  function automatic vec_t mk(int op, int fn, int s, int t, int d, int z,
                              int pc, int fl, int st, int aop, int asrc, int rdst,
                              int mr, int mw, int wr, int wsrc, int wdst);
    vec_t v;
    v.op = 6'(op); v.fn = 6'(fn); v.rs = 5'(s); v.rt = 5'(t); v.rd = 5'(d); v.z = 1'(z);
    v.pc = 2'(pc); v.fl = 1'(fl); v.st = 1'(st);
    v.aop = 2'(aop); v.asrc = 1'(asrc); v.rdst = 2'(rdst);
    v.mr = 1'(mr); v.mw = 1'(mw); v.wr = 1'(wr); v.wsrc = 2'(wsrc); v.wdst = 5'(wdst);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int fn, input int s, input int t, input int d, input int z);
    opCode = 6'(op); func = 6'(fn); rs = 5'(s); rt = 5'(t); rd = 5'(d); zero = 1'(z);
  endtask

  task automatic check_row(input string tag, input vec_t v);
    chk({tag, " pcSrc"},        int'(pcSrc),        int'(v.pc));
    chk({tag, " flush"},        int'(flush),        int'(v.fl));
    chk({tag, " stall"},        int'(stall),        int'(v.st));
    chk({tag, " ex_ALUOp"},     int'(ex_ALUOp),     int'(v.aop));
    chk({tag, " ex_ALUSrc"},    int'(ex_ALUSrc),    int'(v.asrc));
    chk({tag, " ex_regDst"},    int'(ex_regDst),    int'(v.rdst));
    chk({tag, " mem_memRead"},  int'(mem_memRead),  int'(v.mr));
    chk({tag, " mem_memWrite"}, int'(mem_memWrite), int'(v.mw));
    chk({tag, " wb_regWrite"},  int'(wb_regWrite),  int'(v.wr));
    chk({tag, " wb_regSrc"},    int'(wb_regSrc),    int'(v.wsrc));
    chk({tag, " wb_dst"},       int'(wb_dst),       int'(v.wdst));
  endtask

  initial begin
    //               op  fn     rs rt rd z  pc fl st aop as rd mr mw wr ws wd
    tbl[0]  = mk(NOP, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(R,   F_ADD,  2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(R,   F_SUB,  6, 7, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(LW,  0,      8, 5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(R,   F_ADD,  5, 9,10, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 2, 1);
    tbl[5]  = mk(R,   F_ADD,  5, 9,10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 4);
    tbl[6]  = mk(LW,  0,     11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 5);
    tbl[7]  = mk(R,   F_ADD,  0, 0,12, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(BEQ, 0,     13,14, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 2,10);
    tbl[9]  = mk(NOP, 0,      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    tbl[10] = mk(BNE, 0,     13,14, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2,12);
    tbl[11] = mk(BNE, 0,     13,14, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(ADDI,0,     15, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(BEQ, 0,      3,16, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(BEQ, 0,      3,16, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(JAL, 0,      0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 1, 2, 3);
    tbl[16] = mk(NOP, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
    tbl[17] = mk(NOP, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(R,   F_JR,  31, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0,31);
    tbl[19] = mk(SW,  0,     17,18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(LW,  0,     19,20, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(SLTI,0,     21,22, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    tbl[22] = mk(BEQ, 0,     20, 0, 0, 1, 0, 0, 1, 2, 1, 0, 1, 0, 0, 0, 0);
    tbl[23] = mk(BEQ, 0,     20, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1,20);
    tbl[24] = mk(R,   F_SLT,  1, 2,23, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2,22);
    tbl[25] = mk(R,   63,     0, 0, 7, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0);
    tbl[26] = mk(NOP, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[27] = mk(NOP, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2,23);
    tbl[28] = mk(NOP, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(BEQ, 0, 13, 14, 0, 1);
    rst = 1'b1;
    tick();
    check_row("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      drive(int'(tbl[i].op), int'(tbl[i].fn), int'(tbl[i].rs), int'(tbl[i].rt),
            int'(tbl[i].rd), int'(tbl[i].z));
      #1;
      check_row($sformatf("row%0d", i), tbl[i]);
      tick();
    end

    // Multiply: dut takes 4 EX cycles, dut1 takes 1.
    drive(R, F_MULT, 1, 2, 6, 0); #1;
    chk("mul m0 stall", int'(stall), 0);
    chk("mul1 m0 stall", int'(s_stall), 0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(R, F_ADD, 7, 8, 9, 0); #1;
      chk($sformatf("mul m%0d stall", c), int'(stall), (c < 4) ? 1 : 0);
      chk($sformatf("mul m%0d ex_ALUOp", c), int'(ex_ALUOp), 3);
      chk($sformatf("mul m%0d pcSrc", c), int'(pcSrc), 0);
      if (c == 1) begin
        chk("mul1 m1 stall", int'(s_stall), 0);
        chk("mul1 m1 ex_ALUOp", int'(s_ex_ALUOp), 3);
      end else if (c == 2) begin
        chk("mul1 m2 ex_ALUOp", int'(s_ex_ALUOp), 0);
      end else if (c == 3) begin
        chk("mul1 m3 wb_regWrite", int'(s_wb_regWrite), 1);
        chk("mul1 m3 wb_dst", int'(s_wb_dst), 6);
        chk("mul m3 wb_regWrite", int'(wb_regWrite), 0);
      end else begin
        chk("mul m4 wb_regWrite", int'(wb_regWrite), 0);
      end
      tick();
    end
    drive(NOP, 0, 0, 0, 0, 0); #1;
    chk("mul m5 ex_ALUOp", int'(ex_ALUOp), 0);
    chk("mul m5 ex_regDst", int'(ex_regDst), 1);
    chk("mul m5 wb_regWrite", int'(wb_regWrite), 0);
    tick(); #1;
    chk("mul m6 wb_regWrite", int'(wb_regWrite), 1);
    chk("mul m6 wb_dst", int'(wb_dst), 6);
    chk("mul m6 wb_regSrc", int'(wb_regSrc), 2);
    tick(); #1;
    chk("mul m7 wb_dst", int'(wb_dst), 9);
    tick();

    // Reset with a pipe full of ADDs.
    for (int k = 1; k <= 3; k++) begin
      drive(R, F_ADD, 2, 3, k, 0);
      tick();
    end
    drive(BEQ, 0, 13, 14, 0, 1);
    rst = 1'b1; #1;
    chk("rst0 pcSrc", int'(pcSrc), 0);
    chk("rst0 flush", int'(flush), 0);
    tick(); #1;
    check_row("rst1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rst = 1'b0;
    drive(R, F_ADD, 2, 3, 4, 0); #1;
    chk("rst2 ex_regDst", int'(ex_regDst), 0);
    chk("rst2 wb_regWrite", int'(wb_regWrite), 0);
    tick();
    drive(NOP, 0, 0, 0, 0, 0); #1;
    chk("rst3 ex_regDst", int'(ex_regDst), 1);
    tick(); tick(); #1;
    chk("rst5 wb_regWrite", int'(wb_regWrite), 1);
    chk("rst5 wb_dst", int'(wb_dst), 4);
    chk("rst5 wb_regSrc", int'(wb_regSrc), 2);
    tick();

    // Reset in the middle of a multiply.
    drive(R, F_MULT, 1, 2, 6, 0);
    tick();
    drive(NOP, 0, 0, 0, 0, 0); #1;
    chk("mrst busy stall", int'(stall), 1);
    rst = 1'b1; #1;
    chk("mrst rst stall", int'(stall), 0);
    tick();
    rst = 1'b0; #1;
    chk("mrst after stall", int'(stall), 0);
    chk("mrst after ex_ALUOp", int'(ex_ALUOp), 0);
    tick(); #1;
    chk("mrst later stall", int'(stall), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control unit for the 5-stage MIPS core. Decodes the instruction in ID, carries control bits through ID/EX, EX/MEM and MEM/WB registers, resolves branches and jumps in ID, and detects hazards internally. Hazards covered are load-use, branch-operand dependency and a multi-cycle multiply; each produces a stall. The destination register width and multiply latency are parameters.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width
- MUL_LATENCY, 3, EX cycles taken by MULT (≥1)
- LINK_REG, 31, destination register for JAL

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- opCode  in  6  ID-stage opcode
- func  in  6  ID-stage function field
- rs, rt, rd  in  REG_ADDR_W  ID-stage register fields
- zero  in  1  ID-stage comparator result (rs==rt)
- pcSrc  out  2  0 PC+4, 1 branch target, 2 jump target, 3 register (JR)
- flush  out  1  clear IF/ID next edge
- stall  out  1  hold PC and IF/ID
- ex_ALUOp  out  2  0 add, 1 sub, 2 slt, 3 mul
- ex_ALUSrc  out  1  immediate operand
- ex_regDst  out  2  0 rt, 1 rd, 2 LINK_REG
- mem_memRead, mem_memWrite  out  1  data memory controls
- wb_regWrite  out  1  register write enable
- wb_regSrc  out  2  0 PC+4 link, 1 memory, 2 ALU
- wb_dst  out  REG_ADDR_W  resolved write-back register

## Operation
- Opcodes decoded:
  - RTYPE=0, with func ADD=32, SUB=34, SLT=42, MULT=24, JR=8
  - ADDI=8, SLTI=10, LW=35, SW=43, J=2, JAL=3, BEQ=4, BNE=5
  - Unknown opcode/func decodes to all-zero control (NOP).
- The destination is resolved in ID from regDst and carried down the pipe. Destination 0 never counts as a dependency.
- Source use:
  - rs is used by all except J/JAL.
  - rt is used by RTYPE, SW, BEQ, BNE.
- Load-use stall: the EX instruction has memRead and its dst equals a used source.
- Branch-operand stall: ID holds BEQ, BNE or JR, and the EX instruction has regWrite with a dst equal to a used source. It also stalls when the MEM instruction has memRead with a matching dst.
- Multiply: a MULT entering EX loads a counter with MUL_LATENCY-1.
  - While the counter is non-zero, stall=1, the ID/EX register holds and EX/MEM receives a bubble.
  - The counter decrements each cycle.
- Priority: rst > multiply busy > load-use / branch-operand stall > branch/jump.
- Stall cycle: pcSrc=0, flush=0, and ID/EX receives a bubble (all control 0) unless held by the multiply.
- No stall, ID instruction effects:
  - BEQ: pcSrc={0,zero}, flush=zero.
  - BNE: pcSrc={0,~zero}, flush=~zero.
  - J/JAL: pcSrc=2, flush=1.
  - JR: pcSrc=3, flush=1.
- RTYPE JR never writes a register.
- Stage registers shift ID→EX→MEM→WB every non-held cycle.

## Timing
- Reset (rst high at edge): all stage registers, the counter and wb_dst clear to 0. pcSrc, flush and stall are forced to 0 while rst is high.
- Decode, pcSrc, flush and stall are combinational from the ID inputs and the stage registers, valid in the same cycle.
- Latency, from the edge accepting an instruction in ID:
  - ex_* valid for 1 cycle after.
  - mem_* valid 2 cycles after.
  - wb_* valid 3 cycles after.
- MULT occupies EX for MUL_LATENCY cycles. MUL_LATENCY=1 gives no stall.
- Reset mid-multiply: counter cleared, stall drops in the reset cycle.
- A branch in ID stalled by a dependency re-evaluates zero on the cycle after the stall releases.

## Test plan
- Reset: rst=1 for 2 cycles during a pipe full of ADDs. Required: every output 0 in the cycle after the edge; ADDs re-enter cleanly once rst=0.
- Load-use: LW rt=5, then ADD rs=5. Required: stall=1 for exactly 1 cycle, an ID/EX bubble, ADD reaches EX one cycle late; with rt=0, no stall.
- Branch: BEQ zero=1 with no dependency. Required: pcSrc=1, flush=1 in the same cycle. BNE zero=1 gives pcSrc=0, flush=0.
- Branch dependency: ADDI dst=3, then BEQ rs=3. Required: stall=1 for 1 cycle, pcSrc=0 while stalled, then the branch resolves.
- Multiply: MUL_LATENCY=4, MULT then ADD. Required: stall=1 for 3 cycles, ex_ALUOp=3 held 4 cycles, 3 bubbles reach MEM. MUL_LATENCY=1 gives no stall.
- Jumps/link: JAL. Required: pcSrc=2, flush=1; wb_regWrite=1, wb_dst=31, wb_regSrc=0 after 3 cycles. JR: pcSrc=3, flush=1, wb_regWrite stays 0.
